stdout_uart_tx: RTL and testbench

STDOUT_UART_TX -- requirements
Module: stdout_uart_tx

---
 rtl/stdout_uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/stdout_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_stdout_uart_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stdout_uart_pkg.sv
// rtl/stdout_uart_pkg.sv - shared types and constants for the stdout UART transmitter
package stdout_uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head read and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stdout_uart_tx.sv
// rtl/stdout_uart_tx.sv - buffers processor stdout strobes and sends them as 8N1 UART frames
module stdout_uart_tx
  import stdout_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    stdout,
  input  logic                          stdout_en,
  output logic                          tx,
  output logic                          hold,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("stdout_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("stdout_uart_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (FRAME_BITS != DATA_BITS + 2) begin : g_bad_frame
    $error("stdout_uart_tx: frame must be start + data + stop");
  end

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         cnt_next;
  logic [2:0]            bit_idx;
  logic [2:0]            idx_next;
  logic [DATA_BITS-1:0]  shift;
  logic [DATA_BITS-1:0]  shift_next;
  logic                  tx_next;
  logic                  pop;
  logic                  prev_en;
  logic                  rise;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_head;

  assign rise = stdout_en && !prev_en;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rise),
    .wr_data (stdout),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign hold = (fifo_count >= CNTW'(FIFO_DEPTH - 1));
  assign busy = (state != IDLE) || !fifo_empty;

  // prev_en resets high so a strobe already asserted at reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_en  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      prev_en  <= stdout_en;
      overflow <= overflow | (rise && fifo_full);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
      bit_idx <= idx_next;
      shift   <= shift_next;
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    idx_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_cnt == CNT_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = bit_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (bit_cnt == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = shift >> 1;
          if (bit_idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = STOP;
          end else begin
            idx_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt == CNT_LAST) begin
          cnt_next = '0;
          // Chain straight into the next start bit so queued bytes leave with no gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = bit_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// tb/tb_stdout_uart_tx.sv - scoreboard bench decoding tx frames against queued expected bytes
module tb_stdout_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] stdout;
  logic       stdout_en;
  logic       tx;
  logic       hold;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sbq[$];
  int starts[$];

  stdout_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stdout     (stdout),
    .stdout_en  (stdout_en),
    .tx         (tx),
    .hold       (hold),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decode one frame per start bit, sampling near the middle of each bit.
  initial begin
    logic [7:0] data;
    logic       sbit;
    logic       pbit;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !reset) begin
        starts.push_back(cyc);
        aborted = 1'b0;
        data    = '0;
        sbit    = 1'b1;
        pbit    = 1'b0;
        for (int k = 1; k <= 37; k++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          if (k == 1) sbit = tx;
          else if (k >= 5 && k <= 33 && ((k - 5) % 4) == 0) data[(k - 5) / 4] = tx;
          else if (k == 37) pbit = tx;
        end
        if (!aborted) begin
          if (sbq.size() == 0) begin
            chk("unexpected_frame", int'(data), -1);
          end else begin
            chk("frame_data", int'(data), sbq.pop_front());
            chk("start_bit", int'(sbit), 0);
            chk("stop_bit", int'(pbit), 1);
          end
        end
      end
    end
  end

  task automatic pulse(input logic [7:0] b, input bit expect_tx);
    if (expect_tx) sbq.push_back(int'(b));
    stdout    = b;
    stdout_en = 1'b1;
    @(negedge clk);
    stdout_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n >= 3000), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_gaps(input int nframes);
    chk("frame_count", starts.size(), nframes);
    for (int i = 1; i < starts.size(); i++) begin
      chk("frame_gap", starts[i] - starts[i-1], FRAME);
    end
    starts.delete();
  endtask

  int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
  int exp_hold[6] = '{0, 0, 0, 1, 1, 1};
  int exp_ovf [6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    reset     = 1'b1;
    stdout    = 8'h41;
    stdout_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Strobe held high across reset release must not capture.
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_en_count", int'(fifo_count), 0);
    chk("held_en_tx", int'(tx), 1);
    chk("held_en_busy", int'(busy), 0);

    // Re-arm with a low cycle, then 0x41 from IDLE: tx falls two clocks after capture.
    stdout_en = 1'b0;
    @(negedge clk);
    sbq.push_back(8'h41);
    stdout_en = 1'b1;
    @(negedge clk);
    chk("lat_count_p0", int'(fifo_count), 1);
    chk("lat_tx_p0", int'(tx), 1);
    @(negedge clk);
    chk("lat_count_p1", int'(fifo_count), 0);
    chk("lat_tx_p1", int'(tx), 1);
    @(negedge clk);
    chk("lat_tx_p2", int'(tx), 0);
    stdout_en = 1'b0;
    wait_idle();
    check_gaps(1);

    // Level held for 50 cycles yields exactly one frame.
    stdout    = 8'h55;
    sbq.push_back(8'h55);
    stdout_en = 1'b1;
    repeat (50) @(negedge clk);
    stdout_en = 1'b0;
    wait_idle();
    check_gaps(1);
    chk("level_overflow", int'(overflow), 0);

    // Six strobes during the first frame: fifth fills the FIFO, sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sbq.push_back(i + 1);
      stdout    = 8'(i + 1);
      stdout_en = 1'b1;
      @(negedge clk);
      chk("burst_count", int'(fifo_count), exp_cnt[i]);
      chk("burst_hold", int'(hold), exp_hold[i]);
      chk("burst_overflow", int'(overflow), exp_ovf[i]);
      stdout_en = 1'b0;
      @(negedge clk);
    end
    wait_idle();
    check_gaps(5);
    chk("burst_overflow_sticky", int'(overflow), 1);

    // Push lands on the same edge as the stop-bit pop.
    pulse(8'h11, 1'b1);
    pulse(8'h22, 1'b1);
    repeat (37) @(negedge clk);
    chk("pushpop_before", int'(fifo_count), 1);
    sbq.push_back(8'h33);
    stdout    = 8'h33;
    stdout_en = 1'b1;
    @(negedge clk);
    chk("pushpop_after", int'(fifo_count), 1);
    stdout_en = 1'b0;
    wait_idle();
    check_gaps(3);

    // Reset during data bit 3 of 0xA5 with 0x99 still buffered.
    pulse(8'hA5, 1'b0);
    pulse(8'h99, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tx", int'(tx), 1);
    chk("abort_count", int'(fifo_count), 0);
    chk("abort_overflow", int'(overflow), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_hold", int'(hold), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    wait_idle();
    starts.delete();
    pulse(8'h3C, 1'b1);
    wait_idle();
    check_gaps(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
